rv32_mem_lsu: RTL and testbench

RV32_MEM_LSU -- requirements
Module: rv32_mem_lsu

---
 rtl/rv32_lsu_pkg.sv | 48 ++++
 rtl/rv32_load_align.sv | 34 +++
 rtl/rv32_mem_lsu.sv | 153 +++++++++++++++
 tb/tb_rv32_mem_lsu.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_lsu_pkg.sv
// Shared types and constants for the RV32 load/store unit.
// Latency: n/a (package). Backpressure: n/a.
// Holds the FSM state enum, funct3 size/sign encodings, the default bus
// timeout and small helpers for access legality and byte-lane masks.
package rv32_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    localparam int TIMEOUT_CYC_DEF = 255;

    // funct3 encodings shared by loads and stores (BU/HU are load-only)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Legal encoding for the access kind and natural alignment for its size.
    function automatic logic access_ok(input logic is_store, input logic [2:0] f3,
                                       input logic [1:0] a);
        logic legal;
        logic aligned;
        if (is_store) legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else          legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                              (f3 == F3_BU) || (f3 == F3_HU);
        case (f3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~a[0];
            default: aligned = (a == 2'b00);
        endcase
        return legal && aligned;
    endfunction

    // Byte-lane enables for an access of the given size at the given offset.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/rv32_load_align.sv
// Extracts the addressed byte/half from a bus word and sign/zero extends it.
// Latency: combinational. Backpressure: none.
// Ports: funct3 (size/sign), addr_lo (byte offset), rdata (bus word) -> data.
module rv32_load_align
    import rv32_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'd0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/rv32_mem_lsu.sv
// RV32 MEM-stage load/store unit: one outstanding access on a req/gnt/rvalid bus.
// Latency: load = accept + REQ(>=1) + WAIT(>=1) + DONE; store = accept + REQ(>=1) + DONE.
// Backpressure: stall_out freezes IF..EX/MEM from accept until DONE; bus waits bounded by TIMEOUT_CYC.
// Ports: mem_rd_in/mem_wr_in/funct3_in/addr_in/wdata_in from EX/MEM; stall_out to the
// pipeline; ld_data_out/ld_valid_out to MEM/WB; err_*_out one-cycle error pulses;
// dmem_* word-addressed data bus with byte lanes.
module rv32_mem_lsu
    import rv32_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd_in,
    input  logic        mem_wr_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic        stall_out,
    output logic [31:0] ld_data_out,
    output logic        ld_valid_out,
    output logic        err_misalign_out,
    output logic        err_timeout_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    lsu_state_t    state, state_nxt;
    logic [31:0]   addr_q, wdata_q;
    logic [2:0]    f3_q;
    logic          we_q;
    logic          ld_ok_q;     // last DONE came from a completed load
    logic [CW-1:0] cnt_q;
    logic          accept, ld_cap, timeout, cnt_last;
    logic [31:0]   ld_aligned;

    assign cnt_last = (cnt_q >= CW'(TIMEOUT_CYC - 1));

    rv32_load_align u_align (
        .funct3  (f3_q),
        .addr_lo (addr_q[1:0]),
        .rdata   (dmem_rdata),
        .data    (ld_aligned)
    );

    always_comb begin
        state_nxt        = state;
        accept           = 1'b0;
        ld_cap           = 1'b0;
        timeout          = 1'b0;
        err_misalign_out = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_rd_in || mem_wr_in) begin
                    // rd+wr together is handled as a store
                    if (access_ok(mem_wr_in, funct3_in, addr_in[1:0])) begin
                        accept    = 1'b1;
                        state_nxt = ST_REQ;
                    end else begin
                        err_misalign_out = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                // A completing store grant wins over the timeout; a load grant
                // on the last cycle cannot complete in time, so it is aborted.
                if (dmem_gnt && we_q) begin
                    state_nxt = ST_DONE;
                end else if (cnt_last) begin
                    timeout   = 1'b1;
                    state_nxt = ST_DONE;
                end else if (dmem_gnt) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dmem_rvalid) begin
                    ld_cap    = 1'b1;
                    state_nxt = ST_DONE;
                end else if (cnt_last) begin
                    timeout   = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        stall_out       = accept || (state == ST_REQ) || (state == ST_WAIT);
        err_timeout_out = timeout;
        ld_valid_out    = (state == ST_DONE) && ld_ok_q;
        dmem_req        = 1'b0;
        dmem_we         = 1'b0;
        dmem_addr       = 32'd0;
        dmem_be         = 4'd0;
        dmem_wdata      = 32'd0;
        if (state == ST_REQ) begin
            dmem_req  = 1'b1;
            dmem_we   = we_q;
            dmem_addr = {addr_q[31:2], 2'b00};
            dmem_be   = lane_mask(f3_q[1:0], addr_q[1:0]);
            if (we_q) begin
                case (f3_q[1:0])
                    2'b00:   dmem_wdata = {4{wdata_q[7:0]}};
                    2'b01:   dmem_wdata = {2{wdata_q[15:0]}};
                    default: dmem_wdata = wdata_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            f3_q        <= 3'd0;
            we_q        <= 1'b0;
            ld_ok_q     <= 1'b0;
            ld_data_out <= 32'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q  <= addr_in;
                wdata_q <= wdata_in;
                f3_q    <= funct3_in;
                we_q    <= mem_wr_in;
                ld_ok_q <= 1'b0;
                cnt_q   <= '0;
            end else if ((state == ST_REQ) || (state == ST_WAIT)) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (ld_cap) begin
                ld_data_out <= ld_aligned;
                ld_ok_q     <= 1'b1;
            end
            if (timeout) begin
                ld_data_out <= 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_rv32_mem_lsu.sv
// Directed bench for rv32_mem_lsu: vector table of single accesses plus
// sequences for bus stalls, spurious handshakes, timeout and mid-access reset.
module tb_rv32_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd_in, mem_wr_in;
    logic [2:0]  funct3_in;
    logic [31:0] addr_in, wdata_in;
    logic        stall_out;
    logic [31:0] ld_data_out;
    logic        ld_valid_out, err_misalign_out, err_timeout_out;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;

    always #5 clk = ~clk;

    rv32_mem_lsu #(.TIMEOUT_CYC(255)) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_rd_in        (mem_rd_in),
        .mem_wr_in        (mem_wr_in),
        .funct3_in        (funct3_in),
        .addr_in          (addr_in),
        .wdata_in         (wdata_in),
        .stall_out        (stall_out),
        .ld_data_out      (ld_data_out),
        .ld_valid_out     (ld_valid_out),
        .err_misalign_out (err_misalign_out),
        .err_timeout_out  (err_timeout_out),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_be          (dmem_be),
        .dmem_wdata       (dmem_wdata),
        .dmem_gnt         (dmem_gnt),
        .dmem_rvalid      (dmem_rvalid),
        .dmem_rdata       (dmem_rdata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        string       nm;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  be;
        logic [31:0] bus_wdata;
        logic [31:0] ld;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic rd, input logic wr,
                                input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input logic err, input logic [3:0] be,
                                input logic [31:0] bus_wdata, input logic [31:0] ld);
        vec_t v;
        v.nm = nm; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.err = err; v.be = be; v.bus_wdata = bus_wdata; v.ld = ld;
        return v;
    endfunction

    vec_t vecs[16];

    task automatic check_quiet(input string tag);
        check({tag, "_stall"}, {31'd0, stall_out}, 32'd0);
        check({tag, "_req"}, {31'd0, dmem_req}, 32'd0);
        check({tag, "_we"}, {31'd0, dmem_we}, 32'd0);
        check({tag, "_addr"}, dmem_addr, 32'd0);
        check({tag, "_be"}, {28'd0, dmem_be}, 32'd0);
        check({tag, "_wdata"}, dmem_wdata, 32'd0);
        check({tag, "_ldv"}, {31'd0, ld_valid_out}, 32'd0);
        check({tag, "_errm"}, {31'd0, err_misalign_out}, 32'd0);
        check({tag, "_errt"}, {31'd0, err_timeout_out}, 32'd0);
    endtask

    // One access with grant in the first REQ cycle and rvalid in the first WAIT cycle.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        mem_rd_in = v.rd; mem_wr_in = v.wr; funct3_in = v.f3;
        addr_in = v.addr; wdata_in = v.wdata;
        #1;
        if (v.err) begin
            check({v.nm, "_errm"}, {31'd0, err_misalign_out}, 32'd1);
            check({v.nm, "_stall"}, {31'd0, stall_out}, 32'd0);
            check({v.nm, "_req"}, {31'd0, dmem_req}, 32'd0);
            @(negedge clk);
            mem_rd_in = 1'b0; mem_wr_in = 1'b0;
            #1;
            check({v.nm, "_errm_end"}, {31'd0, err_misalign_out}, 32'd0);
            check({v.nm, "_req_after"}, {31'd0, dmem_req}, 32'd0);
            return;
        end
        check({v.nm, "_stall0"}, {31'd0, stall_out}, 32'd1);
        check({v.nm, "_req0"}, {31'd0, dmem_req}, 32'd0);
        @(negedge clk);
        mem_rd_in = 1'b0; mem_wr_in = 1'b0; dmem_gnt = 1'b1;
        #1;
        check({v.nm, "_req1"}, {31'd0, dmem_req}, 32'd1);
        check({v.nm, "_stall1"}, {31'd0, stall_out}, 32'd1);
        check({v.nm, "_we"}, {31'd0, dmem_we}, {31'd0, v.wr});
        check({v.nm, "_daddr"}, dmem_addr, {v.addr[31:2], 2'b00});
        if (v.wr) begin
            check({v.nm, "_be"}, {28'd0, dmem_be}, {28'd0, v.be});
            check({v.nm, "_dwdata"}, dmem_wdata, v.bus_wdata);
            @(negedge clk);
            dmem_gnt = 1'b0;
            #1;
            check({v.nm, "_done_stall"}, {31'd0, stall_out}, 32'd0);
            check({v.nm, "_done_req"}, {31'd0, dmem_req}, 32'd0);
            check({v.nm, "_done_ldv"}, {31'd0, ld_valid_out}, 32'd0);
        end else begin
            @(negedge clk);
            dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = v.rdata;
            #1;
            check({v.nm, "_wait_req"}, {31'd0, dmem_req}, 32'd0);
            check({v.nm, "_wait_stall"}, {31'd0, stall_out}, 32'd1);
            @(negedge clk);
            dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
            #1;
            check({v.nm, "_ldv"}, {31'd0, ld_valid_out}, 32'd1);
            check({v.nm, "_ld"}, ld_data_out, v.ld);
            check({v.nm, "_done_stall"}, {31'd0, stall_out}, 32'd0);
            @(negedge clk);
            #1;
            check({v.nm, "_ldv_end"}, {31'd0, ld_valid_out}, 32'd0);
            check({v.nm, "_ld_hold"}, ld_data_out, v.ld);
        end
    endtask

    initial begin
        bit found;
        bit req_held;
        int tcyc;

        vecs[0]  = mk("lw_100",   1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 4'h0, 0, 32'hDEADBEEF);
        vecs[1]  = mk("lb_103",   1, 0, 3'b000, 32'h103, 0, 32'h80FFFFFF, 0, 4'h0, 0, 32'hFFFFFF80);
        vecs[2]  = mk("lbu_103",  1, 0, 3'b100, 32'h103, 0, 32'h80FFFFFF, 0, 4'h0, 0, 32'h00000080);
        vecs[3]  = mk("lh_102",   1, 0, 3'b001, 32'h102, 0, 32'h80017FFF, 0, 4'h0, 0, 32'hFFFF8001);
        vecs[4]  = mk("lhu_100",  1, 0, 3'b101, 32'h100, 0, 32'h1234F00D, 0, 4'h0, 0, 32'h0000F00D);
        vecs[5]  = mk("lb_101",   1, 0, 3'b000, 32'h101, 0, 32'h00007F00, 0, 4'h0, 0, 32'h0000007F);
        vecs[6]  = mk("sh_202",   0, 1, 3'b001, 32'h202, 32'h1234ABCD, 0, 0, 4'b1100, 32'hABCDABCD, 0);
        vecs[7]  = mk("sb_301",   0, 1, 3'b000, 32'h301, 32'h000000A5, 0, 0, 4'b0010, 32'hA5A5A5A5, 0);
        vecs[8]  = mk("sw_40c",   0, 1, 3'b010, 32'h40C, 32'hCAFEF00D, 0, 0, 4'b1111, 32'hCAFEF00D, 0);
        vecs[9]  = mk("rdwr_sh",  1, 1, 3'b001, 32'h012, 32'h0000BEEF, 0, 0, 4'b1100, 32'hBEEFBEEF, 0);
        vecs[10] = mk("lw_101",   1, 0, 3'b010, 32'h101, 0, 0, 1, 4'h0, 0, 0);
        vecs[11] = mk("lh_103",   1, 0, 3'b001, 32'h103, 0, 0, 1, 4'h0, 0, 0);
        vecs[12] = mk("sw_402",   0, 1, 3'b010, 32'h402, 0, 0, 1, 4'h0, 0, 0);
        vecs[13] = mk("ld_f3_011",1, 0, 3'b011, 32'h000, 0, 0, 1, 4'h0, 0, 0);
        vecs[14] = mk("st_f3_100",0, 1, 3'b100, 32'h000, 0, 0, 1, 4'h0, 0, 0);
        vecs[15] = mk("sh_201",   0, 1, 3'b001, 32'h201, 0, 0, 1, 4'h0, 0, 0);

        rst = 1'b1;
        mem_rd_in = 0; mem_wr_in = 0; funct3_in = 0; addr_in = 0; wdata_in = 0;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_quiet("reset");
        check("reset_lddata", ld_data_out, 32'd0);

        for (int i = 0; i < 16; i++) run_vec(vecs[i]);

        // Delayed grant with spurious rvalid in REQ and spurious gnt in WAIT;
        // captured fields must not follow changes on the EX/MEM inputs.
        @(negedge clk);
        mem_rd_in = 1; funct3_in = 3'b010; addr_in = 32'h604;
        #1;
        check("dly_stall0", {31'd0, stall_out}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_rd_in = 0; addr_in = 32'hFFFFFFFF;
            dmem_rvalid = 1; dmem_rdata = 32'h11111111;
            #1;
            check("dly_req_held", {31'd0, dmem_req}, 32'd1);
            check("dly_addr_stable", dmem_addr, 32'h604);
        end
        @(negedge clk);
        dmem_rvalid = 0; dmem_gnt = 1;
        #1;
        check("dly_req_gnt", {31'd0, dmem_req}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check("dly_wait_req", {31'd0, dmem_req}, 32'd0);
            check("dly_wait_stall", {31'd0, stall_out}, 32'd1);
            check("dly_wait_ldv", {31'd0, ld_valid_out}, 32'd0);
        end
        @(negedge clk);
        dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 32'h55AA55AA;
        @(negedge clk);
        dmem_rvalid = 0;
        #1;
        check("dly_ldv", {31'd0, ld_valid_out}, 32'd1);
        check("dly_ld", ld_data_out, 32'h55AA55AA);

        // Grant withheld: abort on the 255th cycle in REQ.
        @(negedge clk);
        mem_rd_in = 1; funct3_in = 3'b010; addr_in = 32'h700;
        found = 0; req_held = 1; tcyc = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            mem_rd_in = 0;
            #1;
            if (dmem_req !== 1'b1) req_held = 0;
            if (err_timeout_out === 1'b1) begin
                found = 1; tcyc = i;
                break;
            end
        end
        check("to_seen", {31'd0, found}, 32'd1);
        check("to_cycle", tcyc, 32'd254);
        check("to_req_held", {31'd0, req_held}, 32'd1);
        check("to_stall", {31'd0, stall_out}, 32'd1);
        @(negedge clk);
        #1;
        check("to_pulse_end", {31'd0, err_timeout_out}, 32'd0);
        check("to_ld_zero", ld_data_out, 32'd0);
        check("to_ldv", {31'd0, ld_valid_out}, 32'd0);
        check("to_stall_done", {31'd0, stall_out}, 32'd0);
        @(negedge clk);
        #1;
        check_quiet("to_idle");

        // Reset while in WAIT, then a late rvalid must be ignored.
        run_vec(vecs[0]);
        @(negedge clk);
        mem_rd_in = 1; funct3_in = 3'b010; addr_in = 32'h800;
        @(negedge clk);
        mem_rd_in = 0; dmem_gnt = 1;
        @(negedge clk);
        dmem_gnt = 0;
        #1;
        check("rst_in_wait_stall", {31'd0, stall_out}, 32'd1);
        rst = 1;
        @(negedge clk);
        rst = 0; dmem_rvalid = 1; dmem_rdata = 32'h12345678;
        #1;
        check_quiet("rst_after");
        check("rst_lddata", ld_data_out, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("rst_late_ldv", {31'd0, ld_valid_out}, 32'd0);
            check("rst_late_ld", ld_data_out, 32'd0);
            check("rst_late_stall", {31'd0, stall_out}, 32'd0);
        end
        dmem_rvalid = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
